// File: rtl/register_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Defaults for width/depth plus the count-port width function.
package register_pkg;

    localparam int REG_DEFAULT_WIDTH = 8;
    localparam int REG_DEFAULT_DEPTH = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_stage.sv
// One valid/data slot of the elastic pipeline with enable-hold behaviour.
// Ports: clk, rst (async high), flush, up_valid/up_data in,
//        dn_ready in, rdy out, valid/data out (registered).
module register_stage
    import register_pkg::*;
#(
    parameter int                WIDTH     = REG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Slot can take a word if empty or if its word moves on this edge.
    assign rdy   = !valid_q || dn_ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Flush drops words but leaves the data registers alone.
            valid_d = 1'b0;
        end else if (rdy) begin
            valid_d = up_valid;
            data_d  = up_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH handshaked stages of WIDTH bits.
// Ports: clk, rst, flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count (valid stages).
module register_pipe
    import register_pkg::*;
#(
    parameter int               WIDTH     = REG_DEFAULT_WIDTH,
    parameter int               DEPTH     = REG_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CW = cnt_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_vld;
    logic [DEPTH-1:0] dn_rdy;
    logic [WIDTH-1:0] dat    [DEPTH];
    logic [WIDTH-1:0] up_dat [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_vld[i] = in_valid;
            assign up_dat[i] = in_data;
        end else begin : g_link
            assign up_vld[i] = vld[i-1];
            assign up_dat[i] = dat[i-1];
        end

        // Ready ripples back from the consumer through every stage.
        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy[i] = out_ready;
        end else begin : g_mid
            assign dn_rdy[i] = rdy[i+1];
        end

        register_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_vld[i]),
            .up_data  (up_dat[i]),
            .dn_ready (dn_rdy[i]),
            .rdy      (rdy[i]),
            .valid    (vld[i]),
            .data     (dat[i])
        );
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld[i]);
        end
    end

endmodule

// File: tb/tb_register_pipe.sv
// Self-checking bench for register_pipe (WIDTH=8, DEPTH=4).
// Vector table plus scoreboard and hand-written corner sequences.
module tb_register_pipe;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbq [$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       f;
        logic       eir;
        logic       eov;
        logic [7:0] eod;
        logic [2:0] ecnt;
    } vec_t;

    vec_t vecs [$];

    register_pipe #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic o, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        flush     = f;
        #1;
    endtask

    // Scoreboard bookkeeping for the current cycle, then advance one edge.
    task automatic sb_step();
        logic [7:0] e;
        if (out_valid && out_ready) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got %0h, expected no output",
                         out_data);
            end else begin
                tests--;
                e = sbq.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, e});
            end
        end
        if (flush) sbq.delete();
        if (in_valid && in_ready) sbq.push_back(in_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic o, input logic f);
        drive(v, d, o, f);
        sb_step();
    endtask

    task automatic tv(input logic v, input logic [7:0] d, input logic o,
                      input logic eir, input logic eov,
                      input logic [7:0] eod, input logic [2:0] ecnt);
        vec_t x;
        x.v = v; x.d = d; x.o = o; x.f = 1'b0;
        x.eir = eir; x.eov = eov; x.eod = eod; x.ecnt = ecnt;
        vecs.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", {29'd0, count}, 32'd0);
        chk("rst_od", {24'd0, out_data}, 32'h00);
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with out_ready=1.
        tv(1, 8'haa, 1, 1, 0, 8'h00, 0);
        tv(1, 8'h55, 1, 1, 0, 8'h00, 1);
        tv(1, 8'h0f, 1, 1, 0, 8'h00, 2);
        tv(1, 8'hf0, 1, 1, 0, 8'h00, 3);
        tv(0, 8'h00, 1, 1, 1, 8'haa, 4);
        tv(0, 8'h00, 1, 1, 1, 8'h55, 3);
        tv(0, 8'h00, 1, 1, 1, 8'h0f, 2);
        tv(0, 8'h00, 1, 1, 1, 8'hf0, 1);
        tv(0, 8'h00, 1, 1, 0, 8'h00, 0);
        // Backpressure then release.
        tv(1, 8'h01, 0, 1, 0, 8'h00, 0);
        tv(1, 8'h02, 0, 1, 0, 8'h00, 1);
        tv(1, 8'h03, 0, 1, 0, 8'h00, 2);
        tv(1, 8'h04, 0, 1, 0, 8'h00, 3);
        tv(1, 8'h05, 0, 0, 1, 8'h01, 4);
        tv(1, 8'h05, 0, 0, 1, 8'h01, 4);
        tv(1, 8'h05, 1, 1, 1, 8'h01, 4);
        tv(0, 8'h00, 1, 1, 1, 8'h02, 4);
        tv(0, 8'h00, 1, 1, 1, 8'h03, 3);
        tv(0, 8'h00, 1, 1, 1, 8'h04, 2);
        tv(0, 8'h00, 1, 1, 1, 8'h05, 1);
        tv(0, 8'h00, 1, 1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].o, vecs[i].f);
            chk($sformatf("vec%0d_ir", i), {31'd0, in_ready},
                {31'd0, vecs[i].eir});
            chk($sformatf("vec%0d_ov", i), {31'd0, out_valid},
                {31'd0, vecs[i].eov});
            chk($sformatf("vec%0d_cnt", i), {29'd0, count},
                {29'd0, vecs[i].ecnt});
            if (vecs[i].eov)
                chk($sformatf("vec%0d_od", i), {24'd0, out_data},
                    {24'd0, vecs[i].eod});
            sb_step();
        end

        // Bubble collapse under a stalled consumer.
        cyc(1, 8'haa, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 8'h00, 0, 0);
        drive(1, 8'hbb, 0, 0);
        chk("bub_ov1", {31'd0, out_valid}, 32'd1);
        chk("bub_cnt1", {29'd0, count}, 32'd1);
        sb_step();
        for (int k = 0; k < 2; k++) cyc(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        chk("bub_cnt2", {29'd0, count}, 32'd2);
        chk("bub_od", {24'd0, out_data}, 32'haa);
        chk("bub_ov2", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 1, 0);

        // Flush on a full pipe while offering 77.
        for (int k = 0; k < 4; k++) cyc(1, 8'h31 + 8'(k), 0, 0);
        drive(1, 8'h77, 0, 1);
        chk("fl_ir", {31'd0, in_ready}, 32'd0);
        chk("fl_cnt_pre", {29'd0, count}, 32'd4);
        sb_step();
        drive(0, 8'h00, 0, 0);
        chk("fl_cnt", {29'd0, count}, 32'd0);
        chk("fl_ov", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 6; k++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h88, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 8'h00, 1, 0);

        // Reset asserted mid-cycle during continuous traffic.
        for (int k = 0; k < 6; k++) cyc(1, 8'h10 + 8'(k), 1, 0);
        drive(1, 8'h16, 1, 0);
        chk("mr_ov_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_ov", {31'd0, out_valid}, 32'd0);
        chk("mr_cnt", {29'd0, count}, 32'd0);
        chk("mr_od", {24'd0, out_data}, 32'h00);
        chk("mr_ir", {31'd0, in_ready}, 32'd1);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1, 8'h20 + 8'(k), 1, 0);
        drive(0, 8'h00, 1, 0);
        chk("mr_first", {24'd0, out_data}, 32'h20);
        for (int k = 0; k < 8; k++) cyc(0, 8'h00, 1, 0);

        chk("sb_empty", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_pipe.md
# register_pipe

Parametrised elastic register pipeline: a chain of DEPTH registered stages, each WIDTH bits, joined by a valid/ready handshake. It generalises the single enable-gated register to a multi-stage delay line. Stalled data is held rather than lost, empty stages collapse, and the block adds synchronous flush and occupancy reporting. It sits between producer and consumer blocks wherever a fixed-latency, back-pressurable register slice is needed.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, '0, value loaded into every stage data register on reset
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous: invalidate all stages at the next edge
- in_valid  in  1  producer offers in_data
- in_ready  out  1  pipeline accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  last stage holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  last stage data register, driven directly
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Each stage i (0 = input side, DEPTH-1 = output side) has valid_q[i] and data_q[i].
- Stage readiness is computed combinationally from the output side:
  - rdy[DEPTH-1] = !valid_q[DEPTH-1] || out_ready
  - rdy[i] = !valid_q[i] || rdy[i+1]
- Bubble collapse: a word advances whenever the next stage is empty, even if the consumer is stalled.
- in_ready = rdy[0] && !flush. A transfer occurs on an edge when valid and ready are both 1.
- Stage i loads data_q[i-1] (or in_data for i=0) only when rdy[i] is 1. Otherwise data_q[i] holds its value. This is the enable-hold behaviour, generalised per stage.
- valid_q[i] next = valid of the upstream source when rdy[i] is 1; otherwise it holds.
- out_valid = valid_q[DEPTH-1]. out_data = data_q[DEPTH-1] at all times, including when out_valid is 0.
- count = popcount(valid_q).
- Flush has priority over all transfers. At the next edge all valid_q clear. data_q is unchanged. An in_valid word presented in the flush cycle is dropped (in_ready = 0). An output handshake in the flush cycle still counts as consumed.
- Full pipe with out_ready=1 and in_valid=1: one word is emitted and one accepted on the same edge; count is unchanged.
- Ordering is strictly FIFO. No word is duplicated or dropped except by flush or reset.
- X on in_data while in_valid=0 must never reach out_data when out_valid=1.

## Timing
- Reset (asynchronous, immediate on rst=1):
  - all valid_q = 0 and all data_q = RESET_VAL
  - outputs: out_valid=0, out_data=RESET_VAL, count=0
  - in_ready=1 unless flush=1
- Reset release: normal operation resumes from the first rising edge after rst falls.
- Latency: a word accepted at edge N into an empty pipe is visible at out_valid/out_data after edge N+DEPTH-1. That is DEPTH cycles from the in_valid cycle to the out_valid cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- in_ready has a combinational path from out_ready through the DEPTH-stage ready chain. There is no combinational path from in_* to out_*.

## Structure
- Package register_pkg:
  - REG_DEFAULT_WIDTH=8 and REG_DEFAULT_DEPTH=4
  - function cnt_width(depth), returning $clog2(depth+1)
- Sub-module register_stage (params WIDTH, RESET_VAL):
  - one valid/data pair with clk, rst, flush, up_valid, up_data, dn_ready, rdy output
  - instantiated DEPTH times in a generate loop
- Top level holds the ready chain and the count popcount.

## Test plan
- Async reset: assert rst mid-cycle after loading data → out_valid=0, out_data=00, count=0 before the next edge; in_ready=1.
- Stream with out_ready=1, push aa,55,0f,f0 on consecutive cycles from edge N → out_data aa valid after edge N+3, then 55, 0f, f0 on the following cycles; in_ready stays 1.
- Backpressure with out_ready=0, offer 01..05 → 01..04 accepted, in_ready=0 and count=4 with 05 held. Then raise out_ready → out 01,02,03,04,05 in order with no gaps, and 05 accepted on the first release edge.
- Bubble collapse with out_ready=0: push aa, wait 4 edges, push bb → aa sits in stage 3, bb reaches stage 2 after 3 edges, count=2, out_data=aa.
- Flush on a full pipe with in_valid=1 and in_data=77 → after the edge count=0 and out_valid=0; 77 never appears on the output.
- Reset mid-stream with rst pulsed during continuous traffic → immediate clear; after release, the first output is the first word pushed post-reset.
